rggen_host_if_apb_ex: RTL and testbench

- Next-generation APB host interface for generated register blocks. Bridges APB3/APB4 slave port to the local register bus (request/done handshake, as consumed by rggen_bus_splitter).
- Adds capabilities the existing APB host interface lacks:
  - registered access FSM
  - base-address window decode
  - alignment check
  - optional PPROT write protection
  - registered response path
- Sits between the SoC APB fabric and the bus splitter.

---
 rtl/rggen_rtl_pkg.sv | 28 ++
 rtl/rggen_host_if_timeout_counter.sv | 30 +++
 rtl/rggen_host_if_apb_ex.sv | 133 +++++++++++++
 tb/tb_rggen_host_if_apb_ex.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/rggen_rtl_pkg.sv
// Shared rggen types: bus direction/status, host interface FSM states and
// the alignment-bit helper used by the APB host interface.
package rggen_rtl_pkg;

  typedef enum logic {
    RGGEN_READ  = 1'b0,
    RGGEN_WRITE = 1'b1
  } rggen_direction;

  typedef enum logic [1:0] {
    RGGEN_OKAY         = 2'b00,
    RGGEN_EXOKAY       = 2'b01,
    RGGEN_SLAVE_ERROR  = 2'b10,
    RGGEN_DECODE_ERROR = 2'b11
  } rggen_status;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    BUSY    = 2'b01,
    RESPOND = 2'b10
  } rggen_host_if_state;

  // Number of paddr LSBs that must be zero for a full-width access.
  function automatic int unsigned rggen_alignment_bits(int unsigned data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/rggen_host_if_timeout_counter.sv
// BUSY-state watchdog: counts cycles while enabled, flags expiry on the
// LIMIT-th enabled cycle so the FSM leaves BUSY after exactly LIMIT cycles.
module rggen_host_if_timeout_counter #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned WIDTH = $clog2(LIMIT + 1);
  localparam logic [WIDTH-1:0] LAST = WIDTH'(LIMIT - 1);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign expired = enable && (count == LAST);

endmodule

// File: rtl/rggen_host_if_apb_ex.sv
// APB3/APB4 slave to rggen local bus bridge with window/alignment/PPROT checks
// and a registered response. Optional BUSY timeout: RGGEN_HOST_IF_APB_EX_TIMEOUT_EN.
module rggen_host_if_apb_ex
  import rggen_rtl_pkg::*;
#(
  parameter int unsigned               ADDRESS_WIDTH       = 32,
  parameter int unsigned               LOCAL_ADDRESS_WIDTH = 16,
  parameter logic [ADDRESS_WIDTH-1:0]  BASE_ADDRESS        = '0,
  parameter int unsigned               DATA_WIDTH          = 32,
  parameter int unsigned               APB4                = 1,
  parameter int unsigned               PPROT_CHECK         = 0,
  parameter int unsigned               TIMEOUT_CYCLES      = 255
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           psel,
  input  logic                           penable,
  input  logic [ADDRESS_WIDTH-1:0]       paddr,
  input  logic                           pwrite,
  input  logic [DATA_WIDTH-1:0]          pwdata,
  input  logic [DATA_WIDTH/8-1:0]        pstrb,
  input  logic [2:0]                     pprot,
  output logic                           pready,
  output logic [DATA_WIDTH-1:0]          prdata,
  output logic                           pslverr,
  output logic                           bus_request,
  output logic [LOCAL_ADDRESS_WIDTH-1:0] bus_address,
  output logic                           bus_direction,
  output logic [DATA_WIDTH-1:0]          bus_write_data,
  output logic [DATA_WIDTH/8-1:0]        bus_write_strobe,
  input  logic                           bus_done,
  input  logic [DATA_WIDTH-1:0]          bus_read_data,
  input  logic [1:0]                     bus_status
);

  localparam int unsigned STROBE_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned ALIGN_BITS   = rggen_alignment_bits(DATA_WIDTH);

  rggen_host_if_state               state;
  rggen_direction                   direction;
  logic [LOCAL_ADDRESS_WIDTH-1:0]   address;
  logic [DATA_WIDTH-1:0]            write_data;
  logic [STROBE_WIDTH-1:0]          write_strobe;
  logic [DATA_WIDTH-1:0]            read_data;
  logic                             error;

  logic                             access;
  logic                             window_miss;
  logic                             misaligned;
  logic                             prot_miss;
  logic                             reject;
  logic [STROBE_WIDTH-1:0]          strobe_in;
  logic                             timeout;
  logic                             unused_bits;

  assign access      = psel && penable;
  assign window_miss = paddr[ADDRESS_WIDTH-1:LOCAL_ADDRESS_WIDTH] !=
                       BASE_ADDRESS[ADDRESS_WIDTH-1:LOCAL_ADDRESS_WIDTH];
  assign misaligned  = |paddr[ALIGN_BITS-1:0];
  assign prot_miss   = (PPROT_CHECK != 0) && (APB4 != 0) && pwrite && !pprot[0];
  assign reject      = window_miss || misaligned || prot_miss;
  assign strobe_in   = !pwrite ? '0 : (APB4 != 0) ? pstrb : '1;
  assign unused_bits = ^{pprot[2:1], bus_status[0]};

`ifdef RGGEN_HOST_IF_APB_EX_TIMEOUT_EN
  rggen_host_if_timeout_counter #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout_counter (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (state != BUSY),
    .enable  ((state == BUSY) && !bus_done),
    .expired (timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      direction    <= RGGEN_READ;
      address      <= '0;
      write_data   <= '0;
      write_strobe <= '0;
      read_data    <= '0;
      error        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (access) begin
            direction    <= rggen_direction'(pwrite);
            address      <= paddr[LOCAL_ADDRESS_WIDTH-1:0];
            write_data   <= pwdata;
            write_strobe <= strobe_in;
            if (reject) begin
              read_data <= '0;
              error     <= 1'b1;
              state     <= RESPOND;
            end else begin
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          // bus_done wins over a timeout expiring in the same cycle
          if (bus_done) begin
            read_data <= ((direction == RGGEN_WRITE) || bus_status[1]) ? '0 : bus_read_data;
            error     <= bus_status[1];
            state     <= RESPOND;
          end else if (timeout) begin
            read_data <= '0;
            error     <= 1'b1;
            state     <= RESPOND;
          end
        end
        RESPOND: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus_request      = state == BUSY;
  assign bus_address      = address;
  assign bus_direction    = direction;
  assign bus_write_data   = write_data;
  assign bus_write_strobe = write_strobe;

  assign pready  = state == RESPOND;
  assign prdata  = pready ? read_data : '0;
  assign pslverr = pready && error;

endmodule

// File: tb/tb_rggen_host_if_apb_ex.sv
// Self-checking bench for rggen_host_if_apb_ex: directed cases plus random APB
// transfers checked against a transaction-level reference model.
module tb_rggen_host_if_apb_ex;

  localparam int unsigned AW = 32;
  localparam int unsigned LAW = 16;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 8;
  localparam logic [31:0] BASE = 32'h4000_0000;

`ifdef RGGEN_HOST_IF_APB_EX_TIMEOUT_EN
  localparam bit TIMEOUT_ON = 1'b1;
`else
  localparam bit TIMEOUT_ON = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic            psel, penable, pwrite;
  logic [AW-1:0]   paddr;
  logic [DW-1:0]   pwdata;
  logic [3:0]      pstrb;
  logic [2:0]      pprot;
  logic            pready, pslverr;
  logic [DW-1:0]   prdata;
  logic            bus_request, bus_direction, bus_done;
  logic [LAW-1:0]  bus_address;
  logic [DW-1:0]   bus_write_data, bus_read_data;
  logic [3:0]      bus_write_strobe;
  logic [1:0]      bus_status;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  rggen_host_if_apb_ex #(
    .ADDRESS_WIDTH       (AW),
    .LOCAL_ADDRESS_WIDTH (LAW),
    .BASE_ADDRESS        (BASE),
    .DATA_WIDTH          (DW),
    .APB4                (1),
    .PPROT_CHECK         (1),
    .TIMEOUT_CYCLES      (TO)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .psel             (psel),
    .penable          (penable),
    .paddr            (paddr),
    .pwrite           (pwrite),
    .pwdata           (pwdata),
    .pstrb            (pstrb),
    .pprot            (pprot),
    .pready           (pready),
    .prdata           (prdata),
    .pslverr          (pslverr),
    .bus_request      (bus_request),
    .bus_address      (bus_address),
    .bus_direction    (bus_direction),
    .bus_write_data   (bus_write_data),
    .bus_write_strobe (bus_write_strobe),
    .bus_done         (bus_done),
    .bus_read_data    (bus_read_data),
    .bus_status       (bus_status)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // delay = BUSY cycles before bus_done; delay >= TO means the local bus never answers
  task automatic apb_xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                          input logic [3:0] strb, input logic [2:0] prot, input int delay,
                          input logic [31:0] rdata_in, input logic [1:0] status_in);
    bit reject, expect_timeout, got, fields_ok, req_seen;
    int exp_lat, exp_busy, lat, busy_n, k;
    logic exp_err, obs_err;
    logic [31:0] exp_rdata, obs_rdata;

    reject = (addr[31:16] != BASE[31:16]) || (addr[1:0] != 2'b00) || (wr && !prot[0]);
    expect_timeout = !reject && (delay >= int'(TO));
    if (reject) begin
      exp_lat = 1; exp_busy = 0; exp_err = 1'b1; exp_rdata = '0;
    end else if (expect_timeout) begin
      exp_lat = 1 + int'(TO); exp_busy = int'(TO); exp_err = 1'b1; exp_rdata = '0;
    end else begin
      exp_lat = 2 + delay; exp_busy = delay + 1; exp_err = status_in[1];
      exp_rdata = (wr || status_in[1]) ? 32'h0 : rdata_in;
    end

    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; paddr = addr; pwrite = wr;
    pwdata = wdata; pstrb = strb; pprot = prot;
    @(posedge clk); #1;
    penable = 1'b1;

    got = 0; fields_ok = 1; req_seen = 0; busy_n = 0; k = 0; lat = -1;
    obs_err = 1'bx; obs_rdata = 'x;
    while (!got && k < 60) begin
      @(negedge clk);
      if (pready) begin
        got = 1; lat = k; obs_err = pslverr; obs_rdata = prdata;
      end else begin
        if (bus_request) begin
          req_seen = 1;
          if (bus_address !== addr[15:0] || bus_direction !== wr ||
              bus_write_strobe !== (wr ? strb : 4'h0) || (wr && bus_write_data !== wdata))
            fields_ok = 0;
          if (busy_n == delay) begin
            bus_done = 1'b1; bus_read_data = rdata_in; bus_status = status_in;
          end
          busy_n++;
        end
        @(posedge clk); #1;
        bus_done = 1'b0; bus_read_data = $urandom; bus_status = 2'b00;
        k++;
      end
    end

    check_val("latency", 64'(lat), 64'(exp_lat));
    check_val("bus_request_seen", 64'(req_seen), 64'(!reject));
    check_val("busy_cycles", 64'(busy_n), 64'(exp_busy));
    check_val("bus_fields_stable", 64'(fields_ok), 64'd1);
    check_val("prdata", 64'(obs_rdata), 64'(exp_rdata));
    check_val("pslverr", 64'(obs_err), 64'(exp_err));

    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
    @(negedge clk);
    check_val("pready_single_pulse", 64'(pready), 64'd0);
  endtask

  task automatic stray_done(input string tag);
    @(posedge clk); #1;
    bus_done = 1'b1; bus_read_data = 32'hBAD0_BAD0; bus_status = 2'b10;
    @(negedge clk);
    check_val({tag, "_request"}, 64'(bus_request), 64'd0);
    @(posedge clk); #1;
    bus_done = 1'b0; bus_status = 2'b00;
    @(negedge clk);
    check_val({tag, "_pready"}, 64'(pready), 64'd0);
  endtask

  initial begin
    logic [31:0] a;
    int sel, cnt;
    rst_n = 1'b0; psel = 1'b0; penable = 1'b0; paddr = '0; pwrite = 1'b0;
    pwdata = '0; pstrb = '0; pprot = '0; bus_done = 1'b0; bus_read_data = '0; bus_status = '0;
    #22;
    check_val("rst_pready", 64'(pready), 64'd0);
    check_val("rst_prdata", 64'(prdata), 64'd0);
    check_val("rst_pslverr", 64'(pslverr), 64'd0);
    check_val("rst_bus_request", 64'(bus_request), 64'd0);
    check_val("rst_bus_fields", 64'({bus_address, bus_direction, bus_write_strobe, bus_write_data}), 64'd0);
    #4 rst_n = 1'b1;

    apb_xfer(32'h4000_0010, 1'b0, 32'h0, 4'h0, 3'b001, 0, 32'hDEAD_BEEF, 2'b00);
    apb_xfer(32'h4000_0020, 1'b1, 32'h1234_5678, 4'b0101, 3'b001, 5, 32'hFFFF_FFFF, 2'b00);
    apb_xfer(32'h5000_0000, 1'b0, 32'h0, 4'h0, 3'b001, 0, 32'h1111_1111, 2'b00);
    apb_xfer(32'h4000_0002, 1'b0, 32'h0, 4'h0, 3'b001, 0, 32'h2222_2222, 2'b00);
    apb_xfer(32'h4000_0040, 1'b1, 32'hA5A5_A5A5, 4'hF, 3'b000, 0, 32'h0, 2'b00);
    apb_xfer(32'h4000_0040, 1'b1, 32'hA5A5_A5A5, 4'hF, 3'b001, 1, 32'h0, 2'b00);
    apb_xfer(32'h4000_0044, 1'b0, 32'h0, 4'h0, 3'b000, 2, 32'h3333_3333, 2'b10);
    stray_done("idle_done");

    if (TIMEOUT_ON) begin
      apb_xfer(32'h4000_0080, 1'b0, 32'h0, 4'h0, 3'b001, 1000, 32'h4444_4444, 2'b00);
      repeat (2) @(posedge clk);
      stray_done("late_done");
    end

    // reset while the local access is outstanding
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; paddr = 32'h4000_0100; pwrite = 1'b0;
    @(posedge clk); #1;
    penable = 1'b1;
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!bus_request && cnt < 10);
    check_val("mid_reset_request_seen", 64'(bus_request), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check_val("mid_reset_request", 64'(bus_request), 64'd0);
    check_val("mid_reset_pready", 64'(pready), 64'd0);
    psel = 1'b0; penable = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    apb_xfer(32'h4000_0104, 1'b0, 32'h0, 4'h0, 3'b001, 0, 32'hCAFE_F00D, 2'b00);

    for (int i = 0; i < 80; i++) begin
      sel = $urandom_range(0, 9);
      a = $urandom;
      if (sel == 0)      a[31:16] = ($urandom_range(0, 1) != 0) ? 16'h4001 : 16'h3FFF;
      else if (sel == 1) begin a[31:16] = 16'h4000; a[1:0] = 2'($urandom_range(1, 3)); end
      else               begin a[31:16] = 16'h4000; a[1:0] = 2'b00; end
      apb_xfer(a, 1'($urandom), $urandom, 4'($urandom), 3'($urandom),
               $urandom_range(0, 5), $urandom, 2'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
